sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter PRIO0, default 0, meaning: 1 = port 0 has fixed highest priority; 0 = all three ports are round-robin.
REQ-002 i_clock  in  1  system clock (100 MHz), same domain as the downstream SDRAM interface.
REQ-003 i_reset  in  1  reset, synchronous, active-high.
REQ-004 i_request  in  3  per-port request, bit n = port n.
REQ-005 i_rw  in  3  per-port direction: 1 = write, 0 = read.
REQ-006 i_address  in  96  per-port byte address; port n occupies bits [32n+31:32n].
REQ-007 i_wdata  in  96  per-port write data, same packing as i_address.
REQ-008 o_rdata  out  96  per-port registered read data, same packing.
REQ-009 o_ready  out  3  per-port completion flag.
REQ-010 o_grant  out  2  index of the port currently owning the memory; valid while o_busy = 1.
REQ-011 o_busy  out  1  high in every state other than IDLE.
REQ-012 o_mem_request  out  1  downstream request.
REQ-013 o_mem_rw  out  1  downstream direction.
REQ-014 o_mem_address  out  32  downstream address.
REQ-015 o_mem_wdata  out  32  downstream write data.
REQ-016 i_mem_rdata  in  32  downstream read data.
REQ-017 i_mem_ready  in  1  downstream completion.

Function
REQ-018 Port protocol, upstream and downstream:
- the requester holds request and operands stable until ready = 1;
- ready stays 1 until the requester drops request;
- a port whose o_ready = 1 is not eligible for arbitration.
REQ-019 FSM states: IDLE, ISSUE, RELEASE.
REQ-020 IDLE, at least one eligible request present:
- select a winner;
- latch its index into o_grant;
- latch its rw, address and wdata into the o_mem_* registers;
- set o_mem_request = 1;
- go to ISSUE.
Result: o_mem_request rises exactly 1 cycle after the winning request is sampled.
REQ-021 Round-robin selection:
- the search starts at (last granted + 1) mod 3 and takes the first eligible port;
- after reset, last granted = 2, so port 0 wins first.
REQ-022 PRIO0 = 1: a pending port 0 always wins; otherwise round-robin applies between ports 1 and 2 only.
REQ-023 ISSUE, on i_mem_ready = 1 in the same cycle:
- copy i_mem_rdata into the granted port's o_rdata slice, reads only; writes leave o_rdata unchanged;
- set o_ready[grant] = 1;
- clear o_mem_request;
- go to RELEASE.
Result: port ready arrives 1 cycle after i_mem_ready.
REQ-024 The o_mem_* operand registers SHALL remain constant from the IDLE→ISSUE transition until the return to IDLE.
REQ-025 RELEASE:
- clear o_ready[grant] in the cycle i_request[grant] is sampled 0;
- once i_request[grant] = 0 and i_mem_ready = 0 are both sampled, go to IDLE and update last-granted.
REQ-026 Request and i_mem_ready falling in the same cycle SHALL take one transition: RELEASE→IDLE, with o_ready cleared.
REQ-027 Non-granted ports' o_ready and o_rdata SHALL hold their values while another port is served.
REQ-028 A request that rises while the FSM is in ISSUE or RELEASE SHALL wait and is considered only in IDLE.
REQ-029 A granted requester dropping request during ISSUE (protocol violation):
- the downstream access still completes;
- o_ready[grant] is not set;
- the FSM returns through RELEASE.
REQ-030 Minimum turnaround between two back-to-back grants SHALL be 1 IDLE cycle.

Reset
REQ-031 While i_reset = 1, at the next edge:
- state = IDLE, o_grant = 0, last-granted = 2;
- o_ready = 0, o_rdata = 0, o_busy = 0;
- o_mem_request = 0, o_mem_rw = 0, o_mem_address = 0, o_mem_wdata = 0.
REQ-032 Reset asserted mid-ISSUE SHALL abandon the access without completing it; the downstream interface shares i_reset.

Verification
REQ-033 Single read: p1 reads 0x0000_1000; mem ready after 6 cycles with rdata 0xDEAD_BEEF → o_mem_request rises 1 cycle after the request, o_rdata[63:32] = 0xDEAD_BEEF and o_ready[1] = 1 one cycle after mem ready.
REQ-034 Simultaneous requests from reset: all three ports request in the same cycle, PRIO0 = 0 → grants in order 0, 1, 2, each waiting for the previous requester to drop its request.
REQ-035 PRIO0 = 1: p1 and p2 held requesting, p0 re-requests immediately after each completion → p0 wins every IDLE, and p1/p2 alternate only when p0 is idle.
REQ-036 Write: p2 writes 0x1234_5678 to 0x0010_0004 → o_mem_rw = 1, address and data match and stay stable through ISSUE; o_rdata[95:64] is unchanged.
REQ-037 Slow release: p0 holds its request 5 cycles after ready while p1 requests → o_ready[0] stays 1; no grant to p1 until p0 drops; p1 granted 1 cycle after RELEASE→IDLE.
REQ-038 Reset mid-ISSUE → all outputs reach their reset values next cycle; the first grant after reset goes to port 0.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Three-port arbiter in front of a single-request SDRAM controller port.
// Round-robin by default; PRIO0 = 1 gives port 0 absolute priority over ports 1 and 2.
module sdram_arbiter #(
    parameter int unsigned PRIO0 = 0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [2:0]  i_request,
    input  logic [2:0]  i_rw,
    input  logic [95:0] i_address,
    input  logic [95:0] i_wdata,
    output logic [95:0] o_rdata,
    output logic [2:0]  o_ready,
    output logic [1:0]  o_grant,
    output logic        o_busy,
    output logic        o_mem_request,
    output logic        o_mem_rw,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  grant_reg, grant_next;
    logic [1:0]  last_reg, last_next;
    logic [2:0]  ready_reg, ready_next;
    logic [95:0] rdata_reg, rdata_next;
    logic        mem_request_reg, mem_request_next;
    logic        mem_rw_reg, mem_rw_next;
    logic [31:0] mem_address_reg, mem_address_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;

    // Per-port operands padded to four entries so a 2-bit index never leaves the array.
    logic [31:0] port_address [4];
    logic [31:0] port_wdata   [4];
    logic [3:0]  request4;
    logic [3:0]  rw4;
    logic [2:0]  eligible;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_port
            if (gi < 3) begin : g_real
                assign port_address[gi] = i_address[32*gi +: 32];
                assign port_wdata[gi]   = i_wdata[32*gi +: 32];
            end else begin : g_pad
                assign port_address[gi] = '0;
                assign port_wdata[gi]   = '0;
            end
        end
    endgenerate

    assign request4 = {1'b0, i_request};
    assign rw4      = {1'b0, i_rw};
    // A port still holding ready from its last access must drop request before competing again.
    assign eligible = i_request & ~ready_reg;

    logic [3:0] rr_cand;
    logic [1:0] search0, search1, search2;
    logic [1:0] winner;

    always_comb begin
        rr_cand = {1'b0, eligible};
        if (PRIO0 != 0) begin
            rr_cand[0] = 1'b0;
        end
        case (last_reg)
            2'd0: begin search0 = 2'd1; search1 = 2'd2; search2 = 2'd0; end
            2'd1: begin search0 = 2'd2; search1 = 2'd0; search2 = 2'd1; end
            default: begin search0 = 2'd0; search1 = 2'd1; search2 = 2'd2; end
        endcase
        if (PRIO0 != 0 && eligible[0]) begin
            winner = 2'd0;
        end else if (rr_cand[search0]) begin
            winner = search0;
        end else if (rr_cand[search1]) begin
            winner = search1;
        end else begin
            winner = search2;
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        last_next        = last_reg;
        ready_next       = ready_reg;
        rdata_next       = rdata_reg;
        mem_request_next = mem_request_reg;
        mem_rw_next      = mem_rw_reg;
        mem_address_next = mem_address_reg;
        mem_wdata_next   = mem_wdata_reg;

        case (state_reg)
            IDLE: begin
                if (|eligible) begin
                    grant_next       = winner;
                    mem_rw_next      = rw4[winner];
                    mem_address_next = port_address[winner];
                    mem_wdata_next   = port_wdata[winner];
                    mem_request_next = 1'b1;
                    state_next       = ISSUE;
                end
            end
            ISSUE: begin
                if (i_mem_ready) begin
                    for (int i = 0; i < 3; i++) begin
                        if (grant_reg == 2'(i)) begin
                            if (!mem_rw_reg) begin
                                rdata_next[32*i +: 32] = i_mem_rdata;
                            end
                            // A requester that already gave up is not flagged complete.
                            if (i_request[i]) begin
                                ready_next[i] = 1'b1;
                            end
                        end
                    end
                    mem_request_next = 1'b0;
                    state_next       = RELEASE;
                end
            end
            RELEASE: begin
                if (!request4[grant_reg]) begin
                    for (int i = 0; i < 3; i++) begin
                        if (grant_reg == 2'(i)) begin
                            ready_next[i] = 1'b0;
                        end
                    end
                    if (!i_mem_ready) begin
                        state_next = IDLE;
                        // In priority mode only ports 1 and 2 rotate, so port 0 wins leave the rotation alone.
                        if (PRIO0 == 0 || grant_reg != 2'd0) begin
                            last_next = grant_reg;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg       <= IDLE;
            grant_reg       <= 2'd0;
            last_reg        <= 2'd2;
            ready_reg       <= 3'b000;
            rdata_reg       <= '0;
            mem_request_reg <= 1'b0;
            mem_rw_reg      <= 1'b0;
            mem_address_reg <= '0;
            mem_wdata_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            last_reg        <= last_next;
            ready_reg       <= ready_next;
            rdata_reg       <= rdata_next;
            mem_request_reg <= mem_request_next;
            mem_rw_reg      <= mem_rw_next;
            mem_address_reg <= mem_address_next;
            mem_wdata_reg   <= mem_wdata_next;
        end
    end

    assign o_rdata       = rdata_reg;
    assign o_ready       = ready_reg;
    assign o_grant       = grant_reg;
    assign o_busy        = (state_reg != IDLE);
    assign o_mem_request = mem_request_reg;
    assign o_mem_rw      = mem_rw_reg;
    assign o_mem_address = mem_address_reg;
    assign o_mem_wdata   = mem_wdata_reg;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: instance 0 round-robin, instance 1 with port 0 priority,
// each with its own downstream memory model; grants are scored against a queue of expectations.
module tb_sdram_arbiter;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic [2:0]  req      [2];
    logic [2:0]  rw       [2];
    logic [95:0] addr     [2];
    logic [95:0] wdata    [2];
    logic [95:0] rdata    [2];
    logic [2:0]  rdy      [2];
    logic [1:0]  grant    [2];
    logic        busy     [2];
    logic        mem_req  [2];
    logic        mem_rw   [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata[2];
    logic [31:0] mem_rdata[2];
    logic        mem_ready[2];
    int          mem_lat  [2];
    int          mem_cnt  [2];

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int          inst;
        int          port;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur [2];
    logic prev_req[2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            sdram_arbiter #(.PRIO0(gi)) dut (
                .i_clock      (clock),
                .i_reset      (reset),
                .i_request    (req[gi]),
                .i_rw         (rw[gi]),
                .i_address    (addr[gi]),
                .i_wdata      (wdata[gi]),
                .o_rdata      (rdata[gi]),
                .o_ready      (rdy[gi]),
                .o_grant      (grant[gi]),
                .o_busy       (busy[gi]),
                .o_mem_request(mem_req[gi]),
                .o_mem_rw     (mem_rw[gi]),
                .o_mem_address(mem_addr[gi]),
                .o_mem_wdata  (mem_wdata[gi]),
                .i_mem_rdata  (mem_rdata[gi]),
                .i_mem_ready  (mem_ready[gi])
            );
        end
    endgenerate

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_A5A5);
    endfunction

    // Downstream memory: answers mem_lat cycles after the request, holds ready until request drops.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                mem_ready[k] = 1'b0;
                mem_rdata[k] = '0;
                mem_cnt[k]   = 0;
            end else if (!mem_req[k]) begin
                mem_ready[k] = 1'b0;
                mem_cnt[k]   = 0;
            end else if (!mem_ready[k]) begin
                mem_cnt[k]++;
                if (mem_cnt[k] >= mem_lat[k]) begin
                    mem_ready[k] = 1'b1;
                    mem_rdata[k] = mem_fn(mem_addr[k]);
                end
            end
        end
    end

    // Scoreboard: every new downstream request must match the next expected grant.
    always @(posedge clock) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                prev_req[k] = 1'b0;
            end else begin
                if (mem_req[k] && !prev_req[k]) begin
                    compared++;
                    if (sb_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL sb_empty inst %0d: got grant %0d addr %h, expected no transaction", k, grant[k], mem_addr[k]);
                    end else begin
                        cur[k] = sb_q.pop_front();
                        if (cur[k].inst != k || grant[k] !== 2'(cur[k].port) || mem_rw[k] !== cur[k].rw ||
                            mem_addr[k] !== cur[k].addr || mem_wdata[k] !== cur[k].wdata) begin
                            mismatched++;
                            $display("FAIL grant_order inst %0d: got port %0d rw %0d addr %h wdata %h, expected inst %0d port %0d rw %0d addr %h wdata %h",
                                     k, grant[k], mem_rw[k], mem_addr[k], mem_wdata[k],
                                     cur[k].inst, cur[k].port, cur[k].rw, cur[k].addr, cur[k].wdata);
                        end
                    end
                    $display("txn inst %0d port %0d rw %0d addr %h wdata %h", k, grant[k], mem_rw[k], mem_addr[k], mem_wdata[k]);
                end else if (busy[k]) begin
                    compared++;
                    if (mem_rw[k] !== cur[k].rw || mem_addr[k] !== cur[k].addr || mem_wdata[k] !== cur[k].wdata) begin
                        mismatched++;
                        $display("FAIL operand_hold inst %0d: got rw %0d addr %h wdata %h, expected rw %0d addr %h wdata %h",
                                 k, mem_rw[k], mem_addr[k], mem_wdata[k], cur[k].rw, cur[k].addr, cur[k].wdata);
                    end
                end
                prev_req[k] = mem_req[k];
            end
        end
    end

    task automatic set_port(input int k, input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        rw[k][p]            = w;
        addr[k][32*p +: 32]  = a;
        wdata[k][32*p +: 32] = d;
    endtask

    task automatic push_exp(input int k, input int p);
        exp_t e;
        e.inst  = k;
        e.port  = p;
        e.rw    = rw[k][p];
        e.addr  = addr[k][32*p +: 32];
        e.wdata = wdata[k][32*p +: 32];
        sb_q.push_back(e);
    endtask

    task automatic wait_ready(input int k, input int budget, output int port, output int cycles);
        port   = -1;
        cycles = 0;
        for (int c = 1; c <= budget; c++) begin
            @(posedge clock);
            #1;
            if (rdy[k] != 3'b000) begin
                cycles = c;
                port   = rdy[k][0] ? 0 : (rdy[k][1] ? 1 : 2);
                break;
            end
        end
    endtask

    task automatic wait_idle(input int k, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clock);
            #1;
            if (!busy[k]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drop(input int k, input int port);
        @(negedge clock);
        if (port >= 0) req[k][port] = 1'b0;
        else req[k] = 3'b000;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            compared++;
            if ({rdata[k], mem_addr[k], mem_wdata[k], grant[k], rdy[k], busy[k], mem_req[k], mem_rw[k]} !== '0) begin
                mismatched++;
                $display("FAIL reset_values inst %0d: got grant %0d rdy %b busy %0d mreq %0d mrw %0d maddr %h mwdata %h rdata %h, expected all zero",
                         k, grant[k], rdy[k], busy[k], mem_req[k], mem_rw[k], mem_addr[k], mem_wdata[k], rdata[k]);
            end
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        int port, cyc;
        mem_lat[0] = 6;
        @(negedge clock);
        set_port(0, 1, 1'b0, 32'h0000_1000, 32'h1111_0001);
        push_exp(0, 1);
        req[0][1] = 1'b1;
        @(posedge clock);
        #1;
        compared++;
        if (mem_req[0] !== 1'b1 || grant[0] !== 2'd1) begin
            mismatched++;
            $display("FAIL read_issue: got mem_request %0d grant %0d, expected 1 and 1", mem_req[0], grant[0]);
        end
        wait_ready(0, 30, port, cyc);
        compared++;
        if (port != 1 || cyc != 6) begin
            mismatched++;
            $display("FAIL read_ready: got port %0d after %0d cycles, expected port 1 after 6", port, cyc);
        end
        compared++;
        if (rdata[0] !== {32'h0, 32'hDEAD_BEEF, 32'h0}) begin
            mismatched++;
            $display("FAIL read_data: got %h, expected %h", rdata[0], {32'h0, 32'hDEAD_BEEF, 32'h0});
        end
        drop(0, 1);
        @(posedge clock);
        #1;
        compared++;
        if (rdy[0] !== 3'b000 || busy[0] !== 1'b0 || rdata[0][63:32] !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("FAIL read_release: got rdy %b busy %0d rdata1 %h, expected 000 0 deadbeef", rdy[0], busy[0], rdata[0][63:32]);
        end
    endtask

    task automatic test_simultaneous();
        int port, cyc;
        logic [31:0] a;
        do_reset();
        mem_lat[0] = 2;
        @(negedge clock);
        for (int p = 0; p < 3; p++) begin
            set_port(0, p, 1'b0, 32'h0000_0100 * (p + 1) + 32'h8, 32'hA000_0000 + p);
            push_exp(0, p);
        end
        req[0] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wait_ready(0, 40, port, cyc);
            a = addr[0][32*i +: 32];
            compared++;
            if (port != i || rdata[0][32*i +: 32] !== mem_fn(a)) begin
                mismatched++;
                $display("FAIL rr_order step %0d: got port %0d rdata %h, expected port %0d rdata %h",
                         i, port, rdata[0][32*i +: 32], i, mem_fn(a));
            end
            drop(0, port);
            @(posedge clock);
            #1;
            compared++;
            if (busy[0] !== 1'b0 || rdy[0] !== 3'b000) begin
                mismatched++;
                $display("FAIL rr_idle step %0d: got busy %0d rdy %b, expected 0 000", i, busy[0], rdy[0]);
            end
            if (i < 2) begin
                @(posedge clock);
                #1;
                compared++;
                if (busy[0] !== 1'b1 || grant[0] !== 2'(i + 1)) begin
                    mismatched++;
                    $display("FAIL rr_turnaround step %0d: got busy %0d grant %0d, expected 1 %0d", i, busy[0], grant[0], i + 1);
                end
            end
        end
    endtask

    task automatic test_prio0();
        int port, cyc;
        bit ok;
        int seq[6]   = '{0, 0, 0, 1, 2, 1};
        bit rearm[6] = '{1, 1, 0, 1, 0, 0};
        mem_lat[1] = 2;
        @(negedge clock);
        for (int p = 0; p < 3; p++) begin
            set_port(1, p, 1'b0, 32'h2000_0000 + 32'h40 * p, 32'hB000_0000 + p);
        end
        for (int i = 0; i < 6; i++) push_exp(1, seq[i]);
        req[1] = 3'b111;
        for (int i = 0; i < 6; i++) begin
            wait_ready(1, 40, port, cyc);
            compared++;
            if (port != seq[i]) begin
                mismatched++;
                $display("FAIL prio_order step %0d: got port %0d, expected %0d", i, port, seq[i]);
            end
            drop(1, port);
            if (rearm[i]) begin
                @(negedge clock);
                req[1][seq[i]] = 1'b1;
            end
        end
        wait_idle(1, 10, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL prio_idle: got busy %0d, expected 0", busy[1]);
        end
    endtask

    task automatic test_write();
        int port, cyc;
        bit ok;
        logic [31:0] old;
        mem_lat[0] = 3;
        old = rdata[0][95:64];
        @(negedge clock);
        set_port(0, 2, 1'b1, 32'h0010_0004, 32'h1234_5678);
        push_exp(0, 2);
        req[0][2] = 1'b1;
        @(posedge clock);
        #1;
        compared++;
        if ({mem_req[0], mem_rw[0], mem_addr[0], mem_wdata[0]} !== {1'b1, 1'b1, 32'h0010_0004, 32'h1234_5678}) begin
            mismatched++;
            $display("FAIL write_issue: got req %0d rw %0d addr %h data %h, expected 1 1 00100004 12345678",
                     mem_req[0], mem_rw[0], mem_addr[0], mem_wdata[0]);
        end
        wait_ready(0, 30, port, cyc);
        compared++;
        if (port != 2 || rdata[0][95:64] !== old) begin
            mismatched++;
            $display("FAIL write_done: got port %0d rdata2 %h, expected port 2 rdata2 %h", port, rdata[0][95:64], old);
        end
        drop(0, 2);
        wait_idle(0, 5, ok);
        compared++;
        if (!ok || rw[0][2] !== 1'b1) begin
            mismatched++;
            $display("FAIL write_idle: got busy %0d, expected 0", busy[0]);
        end
    endtask

    task automatic test_violation();
        bit saw_rdy, saw_mem, done;
        mem_lat[0] = 4;
        saw_rdy = 1'b0;
        saw_mem = 1'b0;
        done    = 1'b0;
        @(negedge clock);
        set_port(0, 2, 1'b0, 32'h0000_0300, 32'h3333_3333);
        push_exp(0, 2);
        req[0][2] = 1'b1;
        @(posedge clock);
        #1;
        drop(0, 2);
        for (int c = 0; c < 20; c++) begin
            @(posedge clock);
            #1;
            if (rdy[0][2]) saw_rdy = 1'b1;
            if (mem_ready[0]) saw_mem = 1'b1;
            if (!busy[0]) begin
                done = 1'b1;
                break;
            end
        end
        compared++;
        if (saw_rdy || !saw_mem || !done) begin
            mismatched++;
            $display("FAIL violation: got ready_seen %0d mem_done %0d idle %0d, expected 0 1 1", saw_rdy, saw_mem, done);
        end
    endtask

    task automatic test_slow_release();
        int port, cyc;
        bit ok;
        mem_lat[0] = 2;
        @(negedge clock);
        set_port(0, 0, 1'b0, 32'h0000_0200, 32'h0000_0A0A);
        push_exp(0, 0);
        req[0][0] = 1'b1;
        wait_ready(0, 30, port, cyc);
        compared++;
        if (port != 0) begin
            mismatched++;
            $display("FAIL slow_first: got port %0d, expected 0", port);
        end
        @(negedge clock);
        set_port(0, 1, 1'b0, 32'h0000_0204, 32'h0000_0B0B);
        push_exp(0, 1);
        req[0][1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            compared++;
            if (rdy[0][0] !== 1'b1 || busy[0] !== 1'b1 || grant[0] !== 2'd0 || mem_req[0] !== 1'b0) begin
                mismatched++;
                $display("FAIL slow_hold cycle %0d: got rdy0 %0d busy %0d grant %0d mreq %0d, expected 1 1 0 0",
                         c, rdy[0][0], busy[0], grant[0], mem_req[0]);
            end
        end
        drop(0, 0);
        @(posedge clock);
        #1;
        compared++;
        if (busy[0] !== 1'b0 || rdy[0] !== 3'b000) begin
            mismatched++;
            $display("FAIL slow_idle: got busy %0d rdy %b, expected 0 000", busy[0], rdy[0]);
        end
        @(posedge clock);
        #1;
        compared++;
        if (busy[0] !== 1'b1 || grant[0] !== 2'd1 || mem_req[0] !== 1'b1) begin
            mismatched++;
            $display("FAIL slow_next: got busy %0d grant %0d mreq %0d, expected 1 1 1", busy[0], grant[0], mem_req[0]);
        end
        wait_ready(0, 30, port, cyc);
        drop(0, port);
        wait_idle(0, 5, ok);
        compared++;
        if (port != 1 || !ok) begin
            mismatched++;
            $display("FAIL slow_second: got port %0d idle %0d, expected 1 1", port, ok);
        end
    endtask

    task automatic test_reset_mid_issue();
        int port, cyc;
        bit ok;
        mem_lat[0] = 2;
        @(negedge clock);
        set_port(0, 0, 1'b0, 32'h0000_0400, 32'h0000_0C0C);
        push_exp(0, 0);
        req[0][0] = 1'b1;
        wait_ready(0, 30, port, cyc);
        drop(0, port);
        wait_idle(0, 5, ok);
        mem_lat[0] = 10;
        @(negedge clock);
        set_port(0, 1, 1'b0, 32'h0000_0500, 32'h0000_0D0D);
        push_exp(0, 1);
        req[0][1] = 1'b1;
        @(posedge clock);
        #1;
        compared++;
        if (mem_req[0] !== 1'b1 || grant[0] !== 2'd1 || port != 0) begin
            mismatched++;
            $display("FAIL mid_issue_start: got mreq %0d grant %0d first %0d, expected 1 1 0", mem_req[0], grant[0], port);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset  = 1'b1;
        req[0] = 3'b000;
        @(posedge clock);
        #1;
        compared++;
        if ({rdata[0], mem_addr[0], mem_wdata[0], grant[0], rdy[0], busy[0], mem_req[0], mem_rw[0]} !== '0) begin
            mismatched++;
            $display("FAIL mid_issue_reset: got grant %0d rdy %b busy %0d mreq %0d maddr %h mwdata %h rdata %h, expected all zero",
                     grant[0], rdy[0], busy[0], mem_req[0], mem_addr[0], mem_wdata[0], rdata[0]);
        end
        @(negedge clock);
        reset      = 1'b0;
        mem_lat[0] = 2;
        push_exp(0, 0);
        push_exp(0, 1);
        req[0] = 3'b011;
        wait_ready(0, 30, port, cyc);
        compared++;
        if (port != 0) begin
            mismatched++;
            $display("FAIL post_reset_first: got port %0d, expected 0", port);
        end
        drop(0, port);
        wait_ready(0, 30, port, cyc);
        compared++;
        if (port != 1) begin
            mismatched++;
            $display("FAIL post_reset_second: got port %0d, expected 1", port);
        end
        drop(0, port);
        wait_idle(0, 5, ok);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req[k]     = 3'b000;
            rw[k]      = 3'b000;
            addr[k]    = '0;
            wdata[k]   = '0;
            mem_lat[k] = 2;
        end
        test_reset();
        test_single_read();
        test_simultaneous();
        test_prio0();
        test_write();
        test_violation();
        test_slow_release();
        test_reset_mid_issue();
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL sb_leftover: got %0d pending grants, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
